// File: rtl/button_conditioner_if.sv
// Signal bundle between the raw button inputs and the conditioned event outputs.
// The harness drives through the master modport; button_conditioner uses the slave modport.
interface button_conditioner_if #(
  parameter int NUM_CH = 4
) ();
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] btn_i;
  logic [NUM_CH-1:0] level_o;
  logic [NUM_CH-1:0] strobe_o;
  logic              any_strobe_o;
  logic [IDX_W-1:0]  strobe_idx_o;

  modport master (
    output btn_i,
    input  level_o,
    input  strobe_o,
    input  any_strobe_o,
    input  strobe_idx_o
  );

  modport slave (
    input  btn_i,
    output level_o,
    output strobe_o,
    output any_strobe_o,
    output strobe_idx_o
  );
endinterface

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: synchroniser chain, debounce counter, edge strobe
// and a lowest-index priority summary of the strobes.
module button_conditioner #(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_MODE       = 0
) (
  input  logic                clk,
  input  logic                rst,
  button_conditioner_if.slave bus
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       MODE     = EDGE_MODE[1:0];

  logic [NUM_CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [NUM_CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_CH-1:0]                  level_q, level_d;
  logic [NUM_CH-1:0]                  strobe_q, strobe_d;
  logic [NUM_CH-1:0]                  sync_s;
  logic [IDX_W-1:0]                   idx_s;

  // Plain shift chain: each stage takes the previous stage directly, stage 0 takes the pad.
  always_comb begin
    sync_d = sync_q;
    sync_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sync_d[k] = {sync_q[k][SYNC_STAGES-2:0], bus.btn_i[k]};
      sync_s[k] = sync_q[k][SYNC_STAGES-1];
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    level_d  = level_q;
    strobe_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sync_s[k] == level_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_LAST) begin
        // Change has persisted long enough: accept it and strobe if the direction matches.
        cnt_d[k]   = '0;
        level_d[k] = sync_s[k];
        case (MODE)
          2'd1:    strobe_d[k] = ~sync_s[k];
          2'd2:    strobe_d[k] = 1'b1;
          default: strobe_d[k] = sync_s[k];
        endcase
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      level_q  <= '0;
      strobe_q <= '0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      strobe_q <= strobe_d;
    end
  end

  // Scan from the top so the lowest set strobe wins.
  always_comb begin
    idx_s = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (strobe_q[k]) begin
        idx_s = IDX_W'(k);
      end else begin
        idx_s = idx_s;
      end
    end
  end

  assign bus.level_o      = level_q;
  assign bus.strobe_o     = strobe_q;
  assign bus.any_strobe_o = |strobe_q;
  assign bus.strobe_idx_o = idx_s;
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised multi-channel input conditioner for the FPGA test harness and the final circuit front end. Each channel takes a raw asynchronous pushbutton or switch and passes it through a configurable synchroniser chain. A per-channel debounce counter then qualifies it, and the block emits a clean debounced level plus a one-cycle strobe on the selected edge type. A lowest-index priority encoder summarises all channel strobes so downstream logic can consume button events without per-channel decoding.

## Interface
Parameters:
- NUM_CH, default 4: number of independent input channels; must be ≥1.
- SYNC_STAGES, default 2: synchroniser flops per channel; must be ≥2.
- DEBOUNCE_CYCLES, default 4: consecutive cycles the synchronised input must differ from the accepted level before the change is accepted; must be ≥1.
- EDGE_MODE, default 0: strobe trigger. 0 = rising (0→1 accepted), 1 = falling (1→0 accepted), 2 = both; 3 is reserved and behaves as 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- btn_i  in  NUM_CH  raw asynchronous inputs; bit k is channel k.
- level_o  out  NUM_CH  debounced accepted level per channel.
- strobe_o  out  NUM_CH  one-cycle pulse per channel on an accepted edge that matches EDGE_MODE.
- any_strobe_o  out  1  OR of strobe_o.
- strobe_idx_o  out  max(1,$clog2(NUM_CH))  index of the lowest set bit of strobe_o; 0 when none is set.

## Operation
- Synchroniser: per channel, a chain of SYNC_STAGES flops clocked by clk. The last stage output is s[k]. No combinational logic is allowed between stages.
- Debounce, per channel, holds accepted level L[k] (drives level_o) and counter C[k] of width $clog2(DEBOUNCE_CYCLES+1):
  - s[k] == L[k]: C[k] ← 0.
  - s[k] != L[k] and C[k] < DEBOUNCE_CYCLES-1: C[k] ← C[k]+1.
  - s[k] != L[k] and C[k] == DEBOUNCE_CYCLES-1: L[k] ← s[k], C[k] ← 0, accepted edge.
- Any cycle where s[k] returns to L[k] clears C[k]. Glitches shorter than DEBOUNCE_CYCLES synchronised cycles are fully rejected. The counter never wraps.
- Strobe: strobe_o[k] is registered. It is set to 1 on the same clock edge that updates L[k] when the edge direction matches EDGE_MODE, and to 0 on every other edge. Consequently strobe_o[k] is high exactly during the first cycle of the new level_o[k].
- Channels are fully independent. Simultaneous accepted edges on several channels assert every matching strobe_o bit in the same cycle.
- any_strobe_o and strobe_idx_o are combinational from the strobe_o register. There are no added flops and they carry no extra latency.
- There is no handshake. Strobes are not held or queued; a consumer must sample in the strobe cycle.

## Timing
- Reset (rst high, asynchronous assert): all synchroniser flops, L, C and strobe_o go to 0. Outputs while in reset: level_o = 0, strobe_o = 0, any_strobe_o = 0, strobe_idx_o = 0.
- Reset deassertion is sampled on clk. The first active edge is the first rising clk edge with rst low.
- Reset asserted mid-debounce discards the partial count. No strobe is emitted for an edge that was pending at reset.
- Latency: btn_i[k] changes between clk edges 0 and 1 and then stays stable. s[k] changes at edge SYNC_STAGES. level_o[k] and strobe_o[k] update at edge SYNC_STAGES+DEBOUNCE_CYCLES; with the defaults this is edge 6.
- If btn_i is high during reset, after release level_o rises SYNC_STAGES+DEBOUNCE_CYCLES edges later. That edge is a rising accepted edge and strobes in modes 0 and 2.
- Minimum spacing between two accepted edges on one channel is DEBOUNCE_CYCLES cycles. strobe_o[k] cannot be high on two consecutive cycles unless DEBOUNCE_CYCLES = 1 and the input toggles every cycle.

## Test plan
- Defaults (NUM_CH=4, S=2, D=4, mode 0): reset, then btn_i=4'b0001 held. Required: level_o[0]=1 and strobe_o=4'b0001 at edge 6 for exactly 1 cycle, any_strobe_o=1, strobe_idx_o=0; level_o stays 1 and no further strobes.
- Glitch rejection, defaults: channel 2 high for 3 cycles, then low. Required: level_o[2] stays 0 and strobe_o stays 0 throughout. Repeat with 4 cycles high: level_o[2] pulses to 1 and strobe_o[2] fires once.
- Bounce: channel 1 toggles 1,0,1,1,0,1 then holds 1. Required: exactly one strobe, 6 cycles after the final 0→1 transition.
- Mode 1 and mode 2, each on a separate build: press then release channel 3. Required: mode 1 gives one strobe on release only; mode 2 gives strobes on both press and release, each 6 cycles after its input change.
- Simultaneous: channels 1 and 3 rise in the same cycle. Required: strobe_o=4'b1010 for 1 cycle and strobe_idx_o=1.
- Reset mid-operation: assert rst 2 cycles after a press. Required: all outputs 0 immediately without waiting for clk. After release with btn_i still high, strobe at edge 6 after the first post-reset edge.
